dh_key_ctrl: RTL
================

DH_KEY_CTRL -- requirements
Module: dh_key_ctrl

Interface
REQ-001 Parameters: N=8, operand width; P=89, prime modulus; G=3, generator; TIMEOUT=1024, peer-wait limit in cycles.
REQ-002 Ports, in this order:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request one key exchange; sampled in IDLE only.
- priv_sel  in  1  at start: 1 = use priv_in as private key, 0 = use LFSR.
- priv_in  in  N  externally supplied private key.
- pow_start  out  1  one-cycle start pulse to the modular-powering engine.
- pow_base  out  N  engine base operand.
- pow_exp  out  N  engine exponent operand.
- pow_res  in  N  engine result.
- pow_rdy  in  1  engine done pulse; pow_res is valid in the same cycle.
- tx_data  out  N  own public value.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  link accepts tx_data.
- rx_data  in  N  peer public value.
- rx_valid  in  1  rx_data valid.
- key  out  N  shared secret.
- key_valid  out  1  key valid.
- busy  out  1  exchange in progress.
- err  out  1  sticky error flag.
REQ-003 One clock; reset is asynchronous and active-low.

Function
REQ-004 States: IDLE, GEN, PUB_GO, PUB_WAIT, SEND, PEER, KEY_GO, KEY_WAIT, DONE.
REQ-005 IDLE: on start=1, clear key_valid and err, latch priv_sel, go to GEN; start in any other state is ignored.
REQ-006 GEN: candidate is priv_in if the latched priv_sel=1, else the LFSR value; a candidate in [2, P-2] is latched as priv; go to PUB_GO.
REQ-007 GEN rejection: an LFSR candidate outside [2, P-2] is dropped and the next cycle's LFSR value is retried; a rejected priv_in sets err and returns to IDLE.
REQ-008 LFSR: N-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, free-running every cycle in every state, never zero.
REQ-009 PUB_GO: pow_start=1 for exactly one cycle with pow_base=G, pow_exp=priv; go to PUB_WAIT.
REQ-010 PUB_WAIT: hold pow_base/pow_exp stable; on pow_rdy=1 latch pow_res into tx_data; go to SEND.
REQ-011 SEND: tx_valid=1 with tx_data held; on tx_valid&tx_ready, drop tx_valid next cycle and go to PEER.
REQ-012 PEER: reset the timeout counter on entry; on rx_valid=1 validate rx_data; accept only 2 <= rx_data <= P-2.
REQ-013 PEER, valid rx_data: latch as peer; go to KEY_GO.
REQ-014 PEER, invalid rx_data: set err; return to IDLE.
REQ-015 PEER timeout: counter reaching TIMEOUT-1 without rx_valid sets err and returns to IDLE.
REQ-016 rx_valid outside PEER is ignored.
REQ-017 KEY_GO: pow_start=1 for one cycle with pow_base=peer, pow_exp=priv; go to KEY_WAIT.
REQ-018 KEY_WAIT: on pow_rdy latch pow_res into key; set key_valid; go to DONE.
REQ-019 DONE: key and key_valid hold; next cycle go to IDLE; key_valid stays 1 until the next accepted start or reset.
REQ-020 busy=1 in every state except IDLE and DONE.
REQ-021 err is sticky: cleared only by an accepted start or reset.
REQ-022 pow_rdy outside PUB_WAIT/KEY_WAIT is ignored.
REQ-023 All comparisons are unsigned, N bits wide.

Reset
REQ-024 rst_n=0 at any time, including mid-exchange, forces:
- state to IDLE;
- all outputs to 0;
- priv, peer and timeout counter to 0;
- LFSR to 8'hA5.
REQ-025 Operation resumes on the first clock edge after rst_n deasserts; no pending handshake survives reset.

Structure
REQ-026 A shared package dh_pkg holds the state enumeration, P, G, the LFSR polynomial taps, the LFSR seed and TIMEOUT.
REQ-027 The LFSR is a separate sub-module dh_lfsr (ports clk, rst_n, value).
REQ-028 The modular-powering engine is instantiated outside this block, at the top level, and connected through the pow_* ports.

Verification (P=89, G=3, engine model or real engine attached)
REQ-029 Nominal exchange:
- stimulus: start, priv_sel=1, priv_in=5; tx_ready=1; rx_data=10.
- response: pow_exp=5 with pow_base=3; tx_data=65; second pow_base=10; key=53; key_valid=1; err=0.
REQ-030 Bad peer value:
- stimulus: priv_in=5, rx_data=88.
- response: err=1, return to IDLE, key_valid=0, no second pow_start.
REQ-031 Peer timeout:
- stimulus: no rx_valid for 1024 cycles in PEER.
- response: err=1, busy=0 on the following cycle.
REQ-032 Backpressure:
- stimulus: tx_ready=0 for 20 cycles.
- response: tx_valid=1 and tx_data=65 held stable throughout; PEER entered only after tx_ready=1.
REQ-033 Reset mid-exchange:
- stimulus: rst_n=0 during KEY_WAIT.
- response: all outputs 0 immediately; a new start afterwards completes with key=53.
REQ-034 LFSR path:
- stimulus: priv_sel=0.
- response: latched priv lies in [2,87]; key equals rx_data^priv mod 89, per reference model.

Source files
------------

// File: rtl/dh_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dh_pkg
// Purpose  : Shared constants and types for the Diffie-Hellman key controller:
//            controller state encoding, modulus, generator, LFSR taps and seed,
//            and the peer-wait timeout.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dh_pkg;

  localparam int P       = 89;
  localparam int G       = 3;
  localparam int TIMEOUT = 1024;

  // x^8 + x^6 + x^5 + x^4 + 1 : feedback taken from bits 7, 5, 4, 3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_GEN      = 4'd1,
    S_PUB_GO   = 4'd2,
    S_PUB_WAIT = 4'd3,
    S_SEND     = 4'd4,
    S_PEER     = 4'd5,
    S_KEY_GO   = 4'd6,
    S_KEY_WAIT = 4'd7,
    S_DONE     = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dh_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : dh_lfsr
// Purpose  : Free-running Fibonacci LFSR used as the private-key source.
//            Shifts left every cycle; feedback enters at bit 0.
// Ports    : clk   - clock
//            rst_n - asynchronous active-low reset (loads the seed)
//            value - current LFSR state, never zero
// Revision : 1.0 - initial release
// ============================================================================
module dh_lfsr
  import dh_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [N-1:0] value
);

  localparam logic [N-1:0] c_taps = N'(LFSR_TAPS);
  localparam logic [N-1:0] c_seed = N'(LFSR_SEED);

  logic [N-1:0] r_state;
  logic         w_fb;

  assign w_fb = ^(r_state & c_taps);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_seed;
    end else begin
      r_state <= {r_state[N-2:0], w_fb};
    end
  end

  assign value = r_state;

endmodule
`default_nettype wire

// File: rtl/dh_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dh_key_ctrl
// Purpose  : Sequences one Diffie-Hellman exchange: picks a private key,
//            drives an external modular-powering engine for the public value,
//            sends it, receives and validates the peer value, then drives the
//            engine again for the shared secret.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            start, priv_sel, priv_in   - exchange request and key source
//            pow_start/base/exp         - engine request (registered)
//            pow_res, pow_rdy           - engine response
//            tx_data/valid, tx_ready    - own public value out
//            rx_data, rx_valid          - peer public value in
//            key, key_valid             - shared secret
//            busy, err                  - status (err is sticky)
// Revision : 1.0 - initial release
// ============================================================================
module dh_key_ctrl
  import dh_pkg::*;
#(
  parameter int N       = 8,
  parameter int P       = dh_pkg::P,
  parameter int G       = dh_pkg::G,
  parameter int TIMEOUT = dh_pkg::TIMEOUT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         priv_sel,
  input  logic [N-1:0] priv_in,
  output logic         pow_start,
  output logic [N-1:0] pow_base,
  output logic [N-1:0] pow_exp,
  input  logic [N-1:0] pow_res,
  input  logic         pow_rdy,
  output logic [N-1:0] tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  input  logic [N-1:0] rx_data,
  input  logic         rx_valid,
  output logic [N-1:0] key,
  output logic         key_valid,
  output logic         busy,
  output logic         err
);

  localparam int             CW         = $clog2(TIMEOUT);
  localparam logic [N-1:0]   c_lo       = N'(2);
  localparam logic [N-1:0]   c_hi       = N'(P - 2);
  localparam logic [N-1:0]   c_g        = N'(G);
  localparam logic [CW-1:0]  c_tmo_last = CW'(TIMEOUT - 1);

  state_t        r_state;
  logic          r_sel;
  logic [N-1:0]  r_priv;
  logic [CW-1:0] r_cnt;

  logic          r_pow_start;
  logic [N-1:0]  r_pow_base;   // also serves as the latched peer value
  logic [N-1:0]  r_pow_exp;
  logic [N-1:0]  r_tx_data;
  logic          r_tx_valid;
  logic [N-1:0]  r_key;
  logic          r_key_valid;
  logic          r_busy;
  logic          r_err;

  logic [N-1:0]  w_lfsr;
  logic [N-1:0]  w_cand;
  logic          w_cand_ok;
  logic          w_rx_ok;

  dh_lfsr #(.N(N)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (w_lfsr)
  );

  assign w_cand    = r_sel ? priv_in : w_lfsr;
  assign w_cand_ok = (w_cand >= c_lo) && (w_cand <= c_hi);
  assign w_rx_ok   = (rx_data >= c_lo) && (rx_data <= c_hi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_priv      <= '0;
      r_cnt       <= '0;
      r_pow_start <= 1'b0;
      r_pow_base  <= '0;
      r_pow_exp   <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Engine start is a single-cycle pulse; only the GO transitions raise it.
      r_pow_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key_valid <= 1'b0;
            r_err       <= 1'b0;
            r_sel       <= priv_sel;
            r_busy      <= 1'b1;
            r_state     <= S_GEN;
          end
        end
        S_GEN: begin
          if (w_cand_ok) begin
            r_priv      <= w_cand;
            r_pow_start <= 1'b1;
            r_pow_base  <= c_g;
            r_pow_exp   <= w_cand;
            r_state     <= S_PUB_GO;
          end else if (r_sel) begin
            // A bad external key cannot improve by waiting; LFSR keys retry.
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_PUB_GO: begin
          r_state <= S_PUB_WAIT;
        end
        S_PUB_WAIT: begin
          if (pow_rdy) begin
            r_tx_data  <= pow_res;
            r_tx_valid <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_PEER;
          end
        end
        S_PEER: begin
          if (rx_valid) begin
            if (w_rx_ok) begin
              r_pow_start <= 1'b1;
              r_pow_base  <= rx_data;
              r_pow_exp   <= r_priv;
              r_state     <= S_KEY_GO;
            end else begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (r_cnt == c_tmo_last) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_KEY_GO: begin
          r_state <= S_KEY_WAIT;
        end
        S_KEY_WAIT: begin
          if (pow_rdy) begin
            r_key       <= pow_res;
            r_key_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pow_start = r_pow_start;
  assign pow_base  = r_pow_base;
  assign pow_exp   = r_pow_exp;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule
`default_nettype wire
